mine_placer: RTL and testbench
==============================

MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 Parameter: LFSR_SEED, 16'hACE1, nonzero reset value of the internal LFSR.
REQ-002 Port: clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  single-cycle request to populate a new board.
REQ-005 Port: level  input  2  difficulty: 0 easy (8x8, 19 mines), 1 medium (10x10, 30 mines), 2 hard (15x15, 40 mines), 3 treated as easy; values SHALL be taken from the game package constants.
REQ-006 Port: safe_x, safe_y  input  4 each  field guaranteed mine-free (first click).
REQ-007 Port: busy  output  1  high from the cycle after start is accepted until done.
REQ-008 Port: done  output  1  one-cycle pulse when the last mine has been written.
REQ-009 Port: mine_we  output  1  board write strobe.
REQ-010 Port: mine_x, mine_y  output  4 each  board write address (column, row).
REQ-011 Port: mine_wdata  output  1  board write data (1 = mine, 0 = empty).
REQ-012 Port: mines_placed  output  6  count of mines written in the current run.

Function
REQ-013 The block SHALL use the FSM states IDLE, CLEAR, GEN, WRITE and DONE.
REQ-014 All outputs SHALL be registered.
REQ-015 IDLE: start=1 SHALL latch level, safe_x and safe_y, clear the internal 225-bit occupancy bitmap and mines_placed, and move to CLEAR.
REQ-016 start SHALL be ignored in every state other than IDLE, and the latched values SHALL NOT change during a run.
REQ-017 CLEAR: one write per cycle with mine_wdata=0, covering all dim*dim fields in row-major order (x fastest) from (0,0) to (dim-1,dim-1); mine_we SHALL be high for exactly dim*dim consecutive cycles, the first being the cycle after start is sampled.
REQ-018 After the last clear write, the FSM SHALL go to GEN.
REQ-019 LFSR: 16-bit Fibonacci with taps 16,14,13,11; it SHALL be loaded with LFSR_SEED on reset and advance every cycle in all states.
REQ-020 GEN candidate: x = lfsr[3:0], y = lfsr[7:4].
REQ-021 The candidate SHALL be rejected if x>=dim, y>=dim, the bitmap bit is set, or (x,y)==(safe_x,safe_y); on rejection the FSM SHALL stay in GEN.
REQ-022 GEN, valid candidate: the candidate SHALL be registered onto mine_x/mine_y and the FSM SHALL move to WRITE.
REQ-023 WRITE: mine_we=1 and mine_wdata=1 for exactly one cycle, the bitmap bit SHALL be set, and mines_placed SHALL increment; the FSM SHALL go to DONE if mines_placed reaches mine_num, else back to GEN.
REQ-024 Each accepted mine SHALL therefore take at least 2 cycles, and no coordinate SHALL be written with 1 twice in a run.
REQ-025 DONE: done=1 for one cycle, busy=0 in the same cycle, and the FSM SHALL return to IDLE.
REQ-026 mines_placed SHALL hold its final value until the next accepted start.
REQ-027 A safe_x or safe_y outside the board SHALL exclude no field, with no error raised.
REQ-028 mine_we SHALL be 0 in IDLE, GEN and DONE, and mine_x, mine_y and mine_wdata SHALL hold their last values when mine_we=0.

Reset
REQ-029 On rst_n=0, at any time including mid-run, the FSM SHALL go to IDLE immediately.
REQ-030 Reset values: busy, done, mine_we, mine_wdata, mine_x, mine_y and mines_placed = 0; bitmap cleared; LFSR = LFSR_SEED.
REQ-031 No write strobe SHALL be issued while rst_n=0; a partially written board is left as-is and the next start fully clears it.

Verification
REQ-032 Reset: hold rst_n=0 with start=1 -> all outputs 0, no mine_we; after release and start=0 -> remains IDLE.
REQ-033 Easy, safe (0,0): start -> 64 clear writes (0,0)..(7,7) with wdata 0, then exactly 19 distinct wdata=1 writes all <8 and none at (0,0), mines_placed=19, single done pulse, busy falls with done.
REQ-034 Hard, safe (7,7): -> 225 clear writes, 40 distinct mines with x,y<15 and none at (7,7); scoreboard model of the board has exactly 40 ones.
REQ-035 start pulses during CLEAR and GEN -> ignored; write count and mine count unchanged; exactly one done.
REQ-036 Assert rst_n=0 at the 30th clear write, release, then start with level=3 -> immediate idle outputs, then identical behaviour to easy (64 clears, 19 mines).
REQ-037 Medium, safe (15,15) -> 100 clears, 30 distinct mines <10 with no exclusion; two back-to-back runs without reset produce different layouts, since the LFSR keeps advancing.

Source files
------------

// File: rtl/mine_placer.sv
// Fills a square minesweeper board: clears every field, then writes mine_num
// distinct mines at LFSR-chosen fields, never on the first-click field.
module mine_placer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] level,
    input  logic [3:0] safe_x,
    input  logic [3:0] safe_y,
    output logic       busy,
    output logic       done,
    output logic       mine_we,
    output logic [3:0] mine_x,
    output logic [3:0] mine_y,
    output logic       mine_wdata,
    output logic [5:0] mines_placed
);

    localparam logic [3:0] EASY_DIM   = 4'd8;
    localparam logic [5:0] EASY_MINES = 6'd19;
    localparam logic [3:0] MED_DIM    = 4'd10;
    localparam logic [5:0] MED_MINES  = 6'd30;
    localparam logic [3:0] HARD_DIM   = 4'd15;
    localparam logic [5:0] HARD_MINES = 6'd40;

    typedef enum logic [2:0] {IDLE, CLEAR, GEN, WRITE, DONE} state_t;

    state_t       state;
    logic [1:0]   level_q;
    logic [3:0]   safe_x_q;
    logic [3:0]   safe_y_q;
    logic [224:0] bitmap;
    logic [15:0]  lfsr;

    logic [3:0] dim;
    logic [5:0] mine_num;
    logic [3:0] cand_x;
    logic [3:0] cand_y;
    logic [7:0] cand_idx;
    logic [7:0] wr_idx;
    logic       cand_ok;
    logic       lfsr_fb;

    always_comb begin
        dim      = EASY_DIM;
        mine_num = EASY_MINES;
        case (level_q)
            2'd1: begin dim = MED_DIM;  mine_num = MED_MINES;  end
            2'd2: begin dim = HARD_DIM; mine_num = HARD_MINES; end
            default: begin dim = EASY_DIM; mine_num = EASY_MINES; end
        endcase
    end

    // Bitmap is row-major with a fixed stride of 15 regardless of level.
    always_comb begin
        cand_x   = lfsr[3:0];
        cand_y   = lfsr[7:4];
        cand_idx = {cand_y, 4'b0000} - {4'b0000, cand_y} + {4'b0000, cand_x};
        wr_idx   = {mine_y, 4'b0000} - {4'b0000, mine_y} + {4'b0000, mine_x};
        cand_ok  = (cand_x < dim) && (cand_y < dim) && !bitmap[cand_idx]
                   && !((cand_x == safe_x_q) && (cand_y == safe_y_q));
        lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            level_q      <= 2'd0;
            safe_x_q     <= 4'd0;
            safe_y_q     <= 4'd0;
            bitmap       <= '0;
            lfsr         <= LFSR_SEED;
            busy         <= 1'b0;
            done         <= 1'b0;
            mine_we      <= 1'b0;
            mine_x       <= 4'd0;
            mine_y       <= 4'd0;
            mine_wdata   <= 1'b0;
            mines_placed <= 6'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    mine_we <= 1'b0;
                    if (start) begin
                        level_q      <= level;
                        safe_x_q     <= safe_x;
                        safe_y_q     <= safe_y;
                        bitmap       <= '0;
                        mines_placed <= 6'd0;
                        busy         <= 1'b1;
                        mine_we      <= 1'b1;
                        mine_wdata   <= 1'b0;
                        mine_x       <= 4'd0;
                        mine_y       <= 4'd0;
                        state        <= CLEAR;
                    end
                end
                // mine_x/mine_y double as the clear scan counter.
                CLEAR: begin
                    if ((mine_x == dim - 4'd1) && (mine_y == dim - 4'd1)) begin
                        mine_we <= 1'b0;
                        state   <= GEN;
                    end else if (mine_x == dim - 4'd1) begin
                        mine_x <= 4'd0;
                        mine_y <= mine_y + 4'd1;
                    end else begin
                        mine_x <= mine_x + 4'd1;
                    end
                end
                GEN: begin
                    if (cand_ok) begin
                        mine_x     <= cand_x;
                        mine_y     <= cand_y;
                        mine_we    <= 1'b1;
                        mine_wdata <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    mine_we        <= 1'b0;
                    bitmap[wr_idx] <= 1'b1;
                    mines_placed   <= mines_placed + 6'd1;
                    if (mines_placed + 6'd1 == mine_num) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= GEN;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: per-cycle checks against a board/LFSR model
// plus literal end-of-run expectations for each difficulty.
module tb_mine_placer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] level;
    logic [3:0] safe_x;
    logic [3:0] safe_y;
    logic       busy;
    logic       done;
    logic       mine_we;
    logic [3:0] mine_x;
    logic [3:0] mine_y;
    logic       mine_wdata;
    logic [5:0] mines_placed;

    always #5 clk = ~clk;

    mine_placer #(.LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .level(level),
        .safe_x(safe_x), .safe_y(safe_y), .busy(busy), .done(done),
        .mine_we(mine_we), .mine_x(mine_x), .mine_y(mine_y),
        .mine_wdata(mine_wdata), .mines_placed(mines_placed)
    );

    int errors = 0;
    int checks = 0;
    int exp_dim = 8;
    int exp_num = 19;
    int exp_sx = 0;
    int exp_sy = 0;
    int clr_cnt = 0;
    int mine_cnt = 0;
    int done_cnt = 0;
    bit in_run = 0;
    bit board [16][16];
    logic [15:0] lfsr_cur;
    logic [15:0] lfsr_prev;
    int last_x = 0;
    int last_y = 0;
    int last_wd = 0;
    int last_we = 0;
    logic [255:0] lay1;
    logic [255:0] lay2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR: seeded on reset, one step per rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_cur  = 16'hACE1;
            lfsr_prev = 16'hACE1;
        end else begin
            lfsr_prev = lfsr_cur;
            lfsr_cur  = lfsr_next(lfsr_cur);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_we", mine_we, 0);
            chk("rst_wdata", mine_wdata, 0);
            chk("rst_x", mine_x, 0);
            chk("rst_y", mine_y, 0);
            chk("rst_placed", mines_placed, 0);
            in_run = 0; mine_cnt = 0;
            last_x = 0; last_y = 0; last_wd = 0; last_we = 0;
        end else begin
            chk("placed_count", mines_placed, mine_cnt);
            if (in_run && clr_cnt < exp_dim * exp_dim) begin
                chk("clr_we", mine_we, 1);
                chk("clr_wdata", mine_wdata, 0);
                chk("clr_x", mine_x, clr_cnt % exp_dim);
                chk("clr_y", mine_y, clr_cnt / exp_dim);
                chk("clr_busy", busy, 1);
                chk("clr_done", done, 0);
                clr_cnt++;
            end else if (in_run && done) begin
                chk("done_busy", busy, 0);
                chk("done_we", mine_we, 0);
                chk("done_mines", mine_cnt, exp_num);
                done_cnt++;
                in_run = 0;
            end else if (in_run) begin
                chk("gen_busy", busy, 1);
                if (mine_we) begin
                    chk("mine_wdata", mine_wdata, 1);
                    chk("mine_x_range", int'(mine_x < exp_dim), 1);
                    chk("mine_y_range", int'(mine_y < exp_dim), 1);
                    chk("mine_not_safe", int'(mine_x == exp_sx && mine_y == exp_sy), 0);
                    chk("mine_distinct", board[mine_x][mine_y], 0);
                    chk("mine_x_lfsr", mine_x, lfsr_prev[3:0]);
                    chk("mine_y_lfsr", mine_y, lfsr_prev[7:4]);
                    chk("mine_gap", last_we, 0);
                    board[mine_x][mine_y] = 1'b1;
                    mine_cnt++;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_we", mine_we, 0);
                chk("idle_done", done, 0);
            end
            if (!mine_we) begin
                chk("hold_x", mine_x, last_x);
                chk("hold_y", mine_y, last_y);
                chk("hold_wdata", mine_wdata, last_wd);
            end
            last_x = mine_x; last_y = mine_y; last_wd = mine_wdata; last_we = mine_we;
        end
    end

    task automatic begin_run(input int lv, input int sx, input int sy);
        int d;
        int n;
        case (lv)
            1: begin d = 10; n = 30; end
            2: begin d = 15; n = 40; end
            default: begin d = 8; n = 19; end
        endcase
        @(negedge clk);
        level = lv[1:0]; safe_x = sx[3:0]; safe_y = sy[3:0]; start = 1'b1;
        @(posedge clk);
        exp_dim = d; exp_num = n; exp_sx = sx; exp_sy = sy;
        clr_cnt = 0; mine_cnt = 0; done_cnt = 0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) board[x][y] = 1'b0;
        in_run = 1;
        #1 start = 1'b0;
    endtask

    task automatic finish_run(input int d, input int n);
        int k;
        int ones;
        k = 0;
        ones = 0;
        while (done_cnt == 0 && k < 30000) begin @(posedge clk); k++; end
        repeat (3) @(posedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("mine_total", mine_cnt, n);
        chk("clear_total", clr_cnt, d * d);
        chk("mines_placed_final", mines_placed, n);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) ones += board[x][y];
        chk("board_ones", ones, n);
    endtask

    task automatic pulse_start(input logic [1:0] lv);
        @(negedge clk);
        start = 1'b1; level = lv; safe_x = 4'd1; safe_y = 4'd1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [255:0] layout();
        logic [255:0] v;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) v[y * 16 + x] = board[x][y];
        return v;
    endfunction

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b1; level = 2'd0; safe_x = 4'd0; safe_y = 4'd0;
        repeat (4) @(negedge clk);
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_we", mine_we, 0);

        begin_run(0, 0, 0);
        finish_run(8, 19);

        begin_run(2, 7, 7);
        finish_run(15, 40);

        begin_run(0, 3, 4);
        k = 0;
        while (clr_cnt < 10 && k < 1000) begin @(posedge clk); k++; end
        pulse_start(2'd2);
        k = 0;
        while (!(clr_cnt >= 64 && mine_cnt >= 5) && k < 5000) begin @(posedge clk); k++; end
        pulse_start(2'd1);
        finish_run(8, 19);

        begin_run(1, 2, 2);
        k = 0;
        while (clr_cnt < 30 && k < 1000) begin @(posedge clk); k++; end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_we", mine_we, 0);
        chk("midrst_x", mine_x, 0);
        chk("midrst_placed", mines_placed, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin_run(3, 0, 0);
        finish_run(8, 19);

        begin_run(1, 15, 15);
        finish_run(10, 30);
        lay1 = layout();
        begin_run(1, 15, 15);
        finish_run(10, 30);
        lay2 = layout();
        chk("layouts_differ", int'(lay1 != lay2), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
